// File: rtl/piso_stream.sv
// Parallel-in serial-out word serializer: loads NDATA words of BIT bits, emits word 0 first on a valid/ready stream.
// Optional macro PISO_STREAM_BACKTOBACK_EN lets a load ride on the final beat so frames stream without a bubble.
module piso_stream #(
    parameter int BIT   = 8,
    parameter int NDATA = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    output logic                 o_ready,
    input  logic [BIT*NDATA-1:0] i_data,
    output logic [BIT-1:0]       o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_last
);

    localparam int              CW   = $clog2(NDATA);
    localparam logic [CW-1:0]   LAST = CW'(NDATA - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [BIT-1:0] word_buf [NDATA];
    logic [CW-1:0]  cnt;
    logic           load_acc;
    logic           beat;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        o_valid   = (state == SEND);
        o_last    = (state == SEND) && (cnt == LAST);
`ifdef PISO_STREAM_BACKTOBACK_EN
        o_ready   = (state == IDLE) || (o_last && i_ready);
`else
        o_ready   = (state == IDLE);
`endif
        load_acc  = i_load && o_ready;
        beat      = o_valid && i_ready;

        unique case (state)
            IDLE: if (load_acc) state_nxt = SEND;
            SEND: if (o_last && i_ready) state_nxt = load_acc ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_data = word_buf[0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the word buffer is cleared on reset on purpose, so o_data reads zero whenever nothing is being sent.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            for (int k = 0; k < NDATA; k++) word_buf[k] <= '0;
        end else begin
            state <= state_nxt;
            if (load_acc) begin
                // A load on the final beat (back-to-back build) wins over the shift.
                cnt <= '0;
                for (int k = 0; k < NDATA; k++) word_buf[k] <= i_data[BIT*k +: BIT];
            end else if (beat) begin
                cnt <= o_last ? '0 : cnt + 1'b1;
                for (int k = 0; k < NDATA - 1; k++) word_buf[k] <= word_buf[k+1];
                word_buf[NDATA-1] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream: directed steps plus a word/frame scoreboard and a SIPO loopback collector.
module tb_piso_stream;

    localparam int BIT   = 8;
    localparam int NDATA = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 i_load;
    logic                 o_ready;
    logic [BIT*NDATA-1:0] i_data;
    logic [BIT-1:0]       o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_last;

    piso_stream #(.BIT(BIT), .NDATA(NDATA)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_load (i_load),
        .o_ready(o_ready),
        .i_data (i_data),
        .o_data (o_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_last (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BIT-1:0] data;
        logic           last;
    } beat_t;

    beat_t                sb_words[$];
    logic [BIT*NDATA-1:0] sb_frames[$];
    logic [BIT*NDATA-1:0] collector;
    int                   n_cmp = 0;
    int                   n_err = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [BIT*NDATA-1:0] d);
        beat_t b;
        for (int k = 0; k < NDATA; k++) begin
            b.data = d[BIT*k +: BIT];
            b.last = (k == NDATA - 1);
            sb_words.push_back(b);
        end
        sb_frames.push_back(d);
    endtask

    task automatic load_frame(input logic [BIT*NDATA-1:0] d);
        i_load = 1'b1;
        i_data = d;
        push_frame(d);
        step();
        i_load = 1'b0;
    endtask

    // Runs until the DUT drops o_valid; optionally toggles i_ready at random each cycle.
    task automatic wait_idle(input bit rand_ready);
        bit idle = 1'b0;
        for (int c = 0; c < 200 && !idle; c++) begin
            @(negedge clk);
            if (!o_valid) idle = 1'b1;
            else begin
                step();
                if (rand_ready) i_ready = 1'($urandom_range(0, 1));
            end
        end
        check("idle_reached", 32'(idle), 32'd1);
        i_ready = 1'b1;
        step();
    endtask

    // Scoreboard and SIPO collector: every accepted beat pops one expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
            beat_t b;
            collector = {o_data, collector[BIT*NDATA-1:BIT]};
            check("sb_has_entry", 32'(sb_words.size() != 0), 32'd1);
            if (sb_words.size() != 0) begin
                b = sb_words.pop_front();
                check("beat_data", 32'(o_data), 32'(b.data));
                check("beat_last", 32'(o_last), 32'(b.last));
                if (o_last === 1'b1 && sb_frames.size() != 0)
                    check("loopback_frame", 32'(collector), 32'(sb_frames.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        collector = '0;
        rst_n     = 1'b0;
        i_load    = 1'b0;
        i_data    = '0;
        i_ready   = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_last",  32'(o_last),  32'd0);
        check("rst_data",  32'(o_data),  32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Basic frame with exact cycle timing.
        load_frame(24'h332211);
        @(negedge clk);
        check("basic_w0_valid", 32'(o_valid), 32'd1);
        check("basic_w0_data",  32'(o_data),  32'h11);
        check("basic_w0_ready", 32'(o_ready), 32'd0);
        step();
        @(negedge clk);
        check("basic_w1_data",  32'(o_data),  32'h22);
        check("basic_w1_last",  32'(o_last),  32'd0);
        step();
        @(negedge clk);
        check("basic_w2_data",  32'(o_data),  32'h33);
        check("basic_w2_last",  32'(o_last),  32'd1);
        step();
        @(negedge clk);
        check("basic_idle_valid", 32'(o_valid), 32'd0);
        check("basic_idle_data",  32'(o_data),  32'd0);
        check("basic_idle_ready", 32'(o_ready), 32'd1);
        step();

        // Backpressure on word 1: held three cycles in total.
        load_frame(24'h332211);
        step();
        i_ready = 1'b0;
        @(negedge clk);
        check("bp_hold0_data",  32'(o_data),  32'h22);
        check("bp_hold0_valid", 32'(o_valid), 32'd1);
        step();
        @(negedge clk);
        check("bp_hold1_data",  32'(o_data),  32'h22);
        check("bp_hold1_last",  32'(o_last),  32'd0);
        step();
        i_ready = 1'b1;
        @(negedge clk);
        check("bp_release_data", 32'(o_data), 32'h22);
        step();
        @(negedge clk);
        check("bp_after_data", 32'(o_data), 32'h33);
        check("bp_after_last", 32'(o_last), 32'd1);
        wait_idle(1'b0);

        // Load pulse during word 1 must be ignored.
        load_frame(24'h332211);
        step();
        i_load = 1'b1;
        i_data = 24'hCCBBAA;
        @(negedge clk);
        check("ign_ready_low", 32'(o_ready), 32'd0);
        step();
        i_load = 1'b0;
        @(negedge clk);
        check("ign_w2_data", 32'(o_data), 32'h33);
        wait_idle(1'b0);

        // Reset right after word 0 is accepted drops the rest of the frame.
        load_frame(24'h332211);
        step();
        rst_n = 1'b0;
        sb_words.delete();
        void'(sb_frames.pop_back());
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_data",  32'(o_data),  32'd0);
        check("midrst_ready", 32'(o_ready), 32'd1);
        step();
        load_frame(24'h665544);
        @(negedge clk);
        check("midrst_w0_data", 32'(o_data), 32'h44);
        wait_idle(1'b0);

        // Held load across two frames.
        i_load = 1'b1;
        i_data = 24'h332211;
        push_frame(24'h332211);
        step();
        i_data = 24'h665544;
        push_frame(24'h665544);
        step();
        step();
        @(negedge clk);
        check("b2b_w2_data", 32'(o_data), 32'h33);
        step();
        @(negedge clk);
`ifdef PISO_STREAM_BACKTOBACK_EN
        check("b2b_gap_valid", 32'(o_valid), 32'd1);
        check("b2b_gap_data",  32'(o_data),  32'h44);
`else
        check("b2b_gap_valid", 32'(o_valid), 32'd0);
        check("b2b_gap_data",  32'(o_data),  32'd0);
`endif
        step();
        i_load = 1'b0;
        wait_idle(1'b0);

        // Random frames with random backpressure, rebuilt by the collector.
        for (int f = 0; f < 100; f++) begin
            load_frame(BIT*NDATA'($urandom));
            i_ready = 1'($urandom_range(0, 1));
            wait_idle(1'b1);
        end

        check("sb_words_drained",  32'(sb_words.size()),  32'd0);
        check("sb_frames_drained", 32'(sb_frames.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
# piso_stream

- Parallel-in serial-out word serializer: captures NDATA words of BIT bits in one load, then emits them one word per beat on a valid/ready stream.
- Word 0 is emitted first, word NDATA-1 last.
- Feeding the stream into the team's serial-in parallel-out collector, shifting on every accepted beat, rebuilds the original word array.
- Sits on the transmit side of word-stream links, ahead of any stage that consumes one word per cycle.

## Interface
- BIT, 8, word width in bits (≥1)
- NDATA, 3, words per frame (≥2)
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_load  in  1  parallel load request
- o_ready  out  1  load accepted this cycle when i_load && o_ready
- i_data  in  BIT*NDATA  frame; word k at bits [BIT*k +: BIT]
- o_data  out  BIT  current output word
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts beat when o_valid && i_ready
- o_last  out  1  current beat is word NDATA-1

## Operation
- Internal state:
  - shift buffer buf[0..NDATA-1] of BIT bits;
  - beat counter cnt, width $clog2(NDATA);
  - FSM with states IDLE and SEND.
- Reset (i_rst_n low at edge): state=IDLE, buf all zero, cnt=0.
  - Resulting outputs: o_valid=0, o_last=0, o_data=0, o_ready=1.
- IDLE:
  - o_ready=1, o_valid=0.
  - On i_load: buf[k] ← i_data word k, cnt ← 0, go to SEND.
- SEND:
  - o_valid=1, o_data=buf[0], o_last=(cnt==NDATA-1).
  - i_load without o_ready is ignored; buf is not disturbed.
- Beat handshake (o_valid && i_ready):
  - buf[k] ← buf[k+1] for k<NDATA-1; buf[NDATA-1] ← 0; cnt ← cnt+1.
- Final beat (o_last && i_ready):
  - cnt ← 0, go to IDLE.
  - buf is then all zero, so o_data=0 in IDLE.
- Backpressure: while o_valid && !i_ready, o_data, o_last, cnt and buf hold unchanged.
- o_data is taken directly from buf[0]: no combinational path from i_data or i_ready to o_data.
- Reset mid-frame aborts the frame at the next edge: remaining words are dropped and there is no partial-frame flush.

## Timing
- i_load accepted at edge N → word 0 has o_valid=1 in cycle N+1. Load-to-first-word latency is 1 cycle.
- With i_ready held high, word k is presented in cycle N+1+k; o_last is high in cycle N+NDATA.
- Each stall cycle (i_ready=0) delays all later beats by one cycle.
- Without back-to-back support: IDLE lasts at least one cycle between frames, so the minimum frame period is NDATA+1 cycles.
- o_ready depends only on state (registered) unless the back-to-back macro is defined.

## Configuration
- Macro: PISO_STREAM_BACKTOBACK_EN.
- Defined:
  - o_ready = (state==IDLE) || (o_last && i_ready).
  - A load coinciding with the final-beat handshake reloads buf, resets cnt to 0 and stays in SEND.
  - Frames stream with no bubble, giving a minimum period of NDATA cycles.
  - o_ready becomes combinational from i_ready.
- Undefined:
  - o_ready = (state==IDLE) only.
  - A load during the final beat is ignored.
  - One idle cycle always separates frames.

## Test plan
- Basic frame:
  - Stimulus: BIT=8, NDATA=3, reset, load i_data=24'h332211 with i_ready=1.
  - Response: o_data 8'h11, 8'h22, 8'h33 in the 3 cycles after the load; o_last only on 8'h33; then o_valid=0, o_data=0, o_ready=1.
- Backpressure:
  - Stimulus: same load, i_ready low for 2 cycles while 8'h22 is presented.
  - Response: 8'h22 held 3 cycles with o_valid=1, then 8'h33/o_last; no word lost or duplicated.
- Ignored load:
  - Stimulus: pulse i_load with i_data=24'hCCBBAA during the beat of word 1 of frame 24'h332211.
  - Response: output stays 11, 22, 33; 8'hAA never appears.
- Reset mid-frame:
  - Stimulus: assert i_rst_n=0 for 1 edge right after 8'h11 is accepted.
  - Response: next cycle o_valid=0, o_data=0, o_ready=1; a fresh load of 24'h665544 then emits 44, 55, 66.
- Back-to-back:
  - Stimulus: hold i_load=1 with frames 24'h332211 then 24'h665544, i_ready=1.
  - Response with macro: 11, 22, 33, 44, 55, 66 in 6 consecutive cycles.
  - Response without macro: one o_valid=0 cycle between 33 and 44.
- Reconstruction loopback:
  - Stimulus: connect o_data into the serial-in parallel-out collector, shifting on o_valid && i_ready.
  - Response: after o_last, collector word array equals the loaded i_data words 0..NDATA-1, over 100 random frames with random i_ready.
